// File: rtl/pattern_pkg.sv
// pattern_pkg: shared defaults and sizing helpers for the serial pattern detector.
// Rev 1.0 - initial release.
`default_nettype none

package pattern_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_CNT_W   = 8;

  // The fill counter must be able to hold the value PAT_W itself.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that holds at all-ones; clr beats inc.
// Rev 1.0 - initial release.
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         sat_w;

  assign sat_w = (cnt_q == {W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_w) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_w;

endmodule

`default_nettype wire

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: MSB-first serial pattern matcher with saturating match count.
// Define NONOVERLAP_EN to restart the fill after every match. Rev 1.0 - initial release.
`default_nettype none

module serial_pattern_detector
  import pattern_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_in,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [PAT_W-1:0] window
);

  localparam int                FILL_W    = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  window_q;
  logic [PAT_W-1:0]  window_d;
  logic [PAT_W-1:0]  shift_in;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              match_q;
  logic              match_d;

  assign shift_in = {window_q[PAT_W-2:0], d_in};

  // A match needs PAT_W real samples, so a zero-filled window never qualifies.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    if (en) begin
      window_d = shift_in;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
      match_d = (fill_q >= FILL_LAST) && (shift_in == PATTERN);
`ifdef NONOVERLAP_EN
      if (match_d) begin
        fill_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
    end
  end

  // The count follows the registered pulse, one edge behind it.
  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_q),
    .clr (clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign match  = match_q;
  assign window = window_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
// tb_serial_pattern_detector: directed self-checking bench, PATTERN=1101 with a 3-bit counter.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_serial_pattern_detector;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             d_in;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [PAT_W-1:0] window;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .d_in      (d_in),
    .clr       (clr),
    .match     (match),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat),
    .window    (window)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic e, input logic d, input logic c);
    @(negedge clk);
    en   = e;
    d_in = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    en  = 1'b0;
    clr = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_window", window, 0);
    chk("async_rst_match", match, 0);
    chk("async_rst_cnt", match_cnt, 0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    d_in = 1'b0;
    clr  = 1'b0;

    // Reset applied mid-cycle, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_match", match, 0);
    chk("rst_window", window, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_sat", cnt_sat, 0);
    #19 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("zeros_no_match", match, 0);
    end

    // Single match
    step(1'b1, 1'b1, 1'b0); chk("single_b1", match, 0);
    step(1'b1, 1'b1, 1'b0); chk("single_b2", match, 0);
    step(1'b1, 1'b0, 1'b0); chk("single_b3", match, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("single_match", match, 1);
    chk("single_window", window, 4'b1101);
    chk("single_cnt_lag", match_cnt, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("single_pulse_end", match, 0);
    chk("single_cnt", match_cnt, 1);
    chk("single_window2", window, 4'b1010);

    // Overlap: 1101101
    step(1'b1, 1'b1, 1'b0); chk("ovl_1", match, 0);
    step(1'b1, 1'b1, 1'b0); chk("ovl_2", match, 0);
    step(1'b1, 1'b0, 1'b0); chk("ovl_3", match, 0);
    step(1'b1, 1'b1, 1'b0); chk("ovl_4", match, 1);
    step(1'b1, 1'b1, 1'b0); chk("ovl_5", match, 0);
    step(1'b1, 1'b0, 1'b0); chk("ovl_6", match, 0);
    step(1'b1, 1'b1, 1'b0);
`ifdef NONOVERLAP_EN
    chk("ovl_7", match, 0);
`else
    chk("ovl_7", match, 1);
`endif
    step(1'b1, 1'b0, 1'b0);
    chk("ovl_after", match, 0);
`ifdef NONOVERLAP_EN
    chk("ovl_cnt", match_cnt, 2);
`else
    chk("ovl_cnt", match_cnt, 3);
`endif

    // Clear with en low: count drops, window holds.
    step(1'b0, 1'b0, 1'b1);
    chk("clr_cnt", match_cnt, 0);
    chk("clr_window", window, 4'b1010);

    // Enable gap inside a pattern
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap_pre", window, 4'b1011);
    step(1'b0, 1'b1, 1'b0); chk("gap_hold1", window, 4'b1011); chk("gap_m1", match, 0);
    step(1'b0, 1'b0, 1'b0); chk("gap_hold2", window, 4'b1011); chk("gap_m2", match, 0);
    step(1'b0, 1'b1, 1'b0); chk("gap_hold3", window, 4'b1011); chk("gap_m3", match, 0);
    step(1'b1, 1'b0, 1'b0); chk("gap_b3", match, 0);
    step(1'b1, 1'b1, 1'b0); chk("gap_match", match, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_pulse_end", match, 0);
    chk("gap_cnt", match_cnt, 1);

    // Saturation: 9 back-to-back patterns into a 3-bit counter.
    step(1'b0, 1'b0, 1'b1);
    chk("sat_clr", match_cnt, 0);
    for (int p = 0; p < 9; p++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("sat_loop_match", match, 1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("sat_cnt", match_cnt, 7);
    chk("sat_flag", cnt_sat, 1);

    // clr coincides with the increment edge of a fresh match.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clrinc_match", match, 1);
    chk("clrinc_held", match_cnt, 7);
    step(1'b0, 1'b0, 1'b1);
    chk("clrinc_cnt", match_cnt, 0);
    chk("clrinc_sat", cnt_sat, 0);
    chk("clrinc_pulse_end", match, 0);

    // Reset in the middle of a pattern
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_window", window, 4'b1110);
    pulse_rst();
    step(1'b1, 1'b1, 1'b0);
    chk("mid_no_match", match, 0);
    chk("mid_window_fresh", window, 4'b0001);
    pulse_rst();
    step(1'b1, 1'b1, 1'b0); chk("fresh_1", match, 0);
    step(1'b1, 1'b1, 1'b0); chk("fresh_2", match, 0);
    step(1'b1, 1'b0, 1'b0); chk("fresh_3", match, 0);
    step(1'b1, 1'b1, 1'b0); chk("fresh_match", match, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("fresh_cnt", match_cnt, 1);
    chk("fresh_pulse_end", match, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
